// File: rtl/div_booth_companion_pkg.sv
// Shared constants, state encoding and two's-complement helpers for the sequential divider.
package div_booth_companion_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2,
        StDone = 2'd3
    } div_state_e;

    function automatic logic [DIV_WIDTH-1:0] negate(input logic [DIV_WIDTH-1:0] x);
        return ~x + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // The most negative value maps to itself, which is the correct magnitude read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? negate(x) : x;
    endfunction

endpackage

// File: rtl/div_booth_companion_div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D, keep or restore.
module div_booth_companion_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] r_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        r_sh  = {r_i, q_i[WIDTH-1]};
        trial = r_sh - {1'b0, d_i};
        // R < D <= 2^(WIDTH-1), so the top bit of the shifted R is zero and trial[WIDTH] is a sign.
        if (!trial[WIDTH]) begin
            r_o = trial[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            r_o = r_sh[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_booth_companion.sv
// Sequential signed divider: magnitudes through restoring division, then sign fix-up.
// Lo receives the quotient and Hi the remainder, as for MIPS DIV.
module div_booth_companion
    import div_booth_companion_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             resetlocal,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             done,
    output logic             busy,
    output logic             div0
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             sgn_q_q, sgn_q_d, sgn_r_q, sgn_r_d;
    logic             done_q, done_d, busy_q, busy_d, div0_q, div0_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] step_r, step_q;

    div_booth_companion_div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r_i(r_q),
        .q_i(q_q),
        .d_i(d_q),
        .r_o(step_r),
        .q_o(step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sgn_q_d = sgn_q_q;
        sgn_r_d = sgn_r_q;
        done_d  = done_q;
        busy_d  = busy_q;
        div0_d  = div0_q;
        dz_d    = dz_q;
        if (resetlocal) begin
            q_d     = magnitude(A);
            d_d     = magnitude(B);
            sgn_q_d = A[WIDTH-1] ^ B[WIDTH-1];
            sgn_r_d = A[WIDTH-1];
            r_d     = '0;
            cnt_d   = CNT_W'(WIDTH);
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b0;
            div0_d  = 1'b0;
            // Zero divisor skips the iterations; the flag is raised one edge later from StDone.
            if (B == '0) begin
                state_d = StDone;
                busy_d  = 1'b0;
                dz_d    = 1'b1;
            end else begin
                state_d = StRun;
                busy_d  = 1'b1;
                dz_d    = 1'b0;
            end
        end else begin
            case (state_q)
                StIdle: ;
                StRun: begin
                    r_d   = step_r;
                    q_d   = step_q;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_d == '0) begin
                        state_d = StFix;
                    end
                end
                StFix: begin
                    lo_d    = sgn_q_q ? negate(q_q) : q_q;
                    hi_d    = sgn_r_q ? negate(r_q) : r_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end
                StDone: begin
                    if (dz_q) begin
                        done_d = 1'b1;
                        div0_d = 1'b1;
                        dz_d   = 1'b0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_q_q <= 1'b0;
            sgn_r_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            div0_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sgn_q_q <= sgn_q_d;
            sgn_r_q <= sgn_r_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            div0_q  <= div0_d;
            dz_q    <= dz_d;
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign done = done_q;
    assign busy = busy_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_div_booth_companion.sv
// Directed bench for the sequential signed divider: vector table plus abort/reset/div0 sequences.
module tb_div_booth_companion;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        resetlocal = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] Hi, Lo;
    logic        done, busy, div0;

    int tests = 0;
    int failed = 0;

    div_booth_companion #(
        .WIDTH(32),
        .CNT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .resetlocal(resetlocal),
        .A(A),
        .B(B),
        .Hi(Hi),
        .Lo(Lo),
        .done(done),
        .busy(busy),
        .div0(div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Start edge is edge 0; inputs return to idle 1 time unit after it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        resetlocal = 1'b1;
        @(posedge clk);
        #1;
        resetlocal = 1'b0;
        A = 32'hDEAD_BEEF;
        B = 32'h0BAD_F00D;
    endtask

    // Counts edges after the start edge until done, bounded; busy must stay high until then.
    task automatic wait_done(output int lat, output logic busy_ok);
        lat = 0;
        busy_ok = busy;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    initial begin
        int          lat;
        logic        bok;
        logic        seen_done;

        vecs[0] = '{32'd100,       32'd7,         32'd14,        32'd2};
        vecs[1] = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE};
        vecs[2] = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2};
        vecs[3] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vecs[5] = '{32'd0,         32'd5,         32'd0,         32'd0};
        vecs[6] = '{32'd7,         32'd100,       32'd0,         32'd7};
        vecs[7] = '{32'hFFFFFFFF,  32'd2,         32'd0,         32'hFFFFFFFF};
        vecs[8] = '{32'h7FFFFFFF,  32'd1,         32'h7FFFFFFF,  32'd0};
        vecs[9] = '{32'h80000000,  32'd2,         32'hC0000000,  32'd0};

        #12;
        check("reset_lo", Lo, 32'd0);
        check("reset_hi", Hi, 32'd0);
        check("reset_flags", {29'd0, done, busy, div0}, 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("v%0d_start_clears", i), {Lo | Hi, 31'd0, done} == 0 ? 32'd0 : 32'd1,
                  32'd0);
            wait_done(lat, bok);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd33);
            check($sformatf("v%0d_busy_during", i), {31'd0, bok}, 32'd1);
            check($sformatf("v%0d_lo", i), Lo, vecs[i].lo);
            check($sformatf("v%0d_hi", i), Hi, vecs[i].hi);
            check($sformatf("v%0d_div0_busy", i), {30'd0, div0, busy}, 32'd0);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("v%0d_hold", i), Lo, vecs[i].lo);
        end

        // Divide by zero: flag and done one edge after the start edge.
        start_op(32'd5, 32'd0);
        check("dz_edge0_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("dz_done_div0", {30'd0, done, div0}, 32'd3);
        check("dz_lo_hi", Lo | Hi, 32'd0);
        check("dz_busy", {31'd0, busy}, 32'd0);

        // Abort: restart at edge 10 with 9/4; done must only appear at edge 43.
        start_op(32'd100, 32'd7);
        seen_done = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        start_op(32'd9, 32'd4);
        wait_done(lat, bok);
        check("abort_no_early_done", {31'd0, seen_done}, 32'd0);
        check("abort_latency", 32'(lat + 10), 32'd43);
        check("abort_lo", Lo, 32'd2);
        check("abort_hi", Hi, 32'd1);

        // Asynchronous reset in DONE with a nonzero result, then mid-RUN.
        #3;
        reset = 1'b0;
        #1;
        check("areset_done_lo", Lo, 32'd0);
        check("areset_done_hi", Hi, 32'd0);
        check("areset_done_flag", {31'd0, done}, 32'd0);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_op(32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("areset_run_busy", {31'd0, busy}, 32'd0);
        #3;
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        check("areset_stays_idle", {31'd0, seen_done}, 32'd0);
        check("areset_idle_lo", Lo, 32'd0);

        // Held start reloads every edge; division counts from the last one.
        A = 32'd50;
        B = 32'd6;
        resetlocal = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        resetlocal = 1'b0;
        wait_done(lat, bok);
        check("held_latency", 32'(lat), 32'd33);
        check("held_lo", Lo, 32'd8);
        check("held_hi", Hi, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
